// File: rtl/bounce_pkg.sv
// Shared types and constants for the bouncing sprite engine.
package bounce_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAW  = 3'd1,
        S_WAIT  = 3'd2,
        S_ERASE = 3'd3,
        S_MOVE  = 3'd4
    } state_t;

    // Direction encoding: 1 moves towards larger coordinates, 0 towards smaller.
    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    // Colour written while erasing the old sprite position.
    localparam int COLOR_BLACK = 0;

endpackage

// File: rtl/bounce_sprite_engine_sweep.sv
// box_pixel_sweep: row-major (column fastest) walk over a BOX_SIZE x BOX_SIZE square.
// Counters sit at zero while cleared and wrap back to zero after the last pixel.
module box_pixel_sweep
    import bounce_pkg::*;
#(
    parameter int BOX_SIZE = 4,
    parameter int CNT_W    = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_row,
    output logic [CNT_W-1:0] o_col,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BOX_SIZE - 1);

    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_col;

    // Advance column every enabled cycle, carrying into the row at the end of a line.
    always_ff @(posedge clock) begin
        if (!reset || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_enable) begin
            if (r_col == LAST_IDX) begin
                r_col <= '0;
                r_row <= (r_row == LAST_IDX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == LAST_IDX) && (r_col == LAST_IDX);

endmodule

// File: rtl/bounce_sprite_engine.sv
// bounce_sprite_engine: moves a square sprite around the screen, bouncing off the
// edges, and streams one pixel write per cycle to a VGA adapter.
// Build option SPRITE_TRAIL_EN: skip the erase sweep so the sprite leaves a trail.
module bounce_sprite_engine
    import bounce_pkg::*;
#(
    parameter int X_W             = 8,
    parameter int Y_W             = 7,
    parameter int COLOR_W         = 3,
    parameter int SCREEN_W        = 160,
    parameter int SCREEN_H        = 120,
    parameter int BOX_SIZE        = 4,
    parameter int STEP            = 1,
    parameter int TICKS_PER_FRAME = 833333,
    parameter int FRAMES_PER_STEP = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               go,
    input  logic [X_W-1:0]     x_init,
    input  logic [Y_W-1:0]     y_init,
    input  logic [COLOR_W-1:0] color_in,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic               busy,
    output logic               frame_tick
);

    localparam int CNT_W = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1;
    localparam int D_W   = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam int F_W   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    // Edge limits and step are kept one bit wider so no comparison can wrap.
    localparam logic [X_W:0]     MAX_X        = (X_W + 1)'(SCREEN_W - BOX_SIZE);
    localparam logic [Y_W:0]     MAX_Y        = (Y_W + 1)'(SCREEN_H - BOX_SIZE);
    localparam logic [X_W:0]     STEP_X       = (X_W + 1)'(STEP);
    localparam logic [Y_W:0]     STEP_Y       = (Y_W + 1)'(STEP);
    localparam logic [D_W-1:0]   DELAY_RELOAD = D_W'(TICKS_PER_FRAME - 1);
    localparam logic [F_W-1:0]   FRAME_RELOAD = F_W'(FRAMES_PER_STEP - 1);

    state_t             r_state;
    state_t             w_next;
    logic [X_W-1:0]     r_pos_x;
    logic [Y_W-1:0]     r_pos_y;
    logic               r_dir_x;
    logic               r_dir_y;
    logic [COLOR_W-1:0] r_sprite_color;
    logic [D_W-1:0]     r_delay;
    logic [F_W-1:0]     r_frame;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [COLOR_W-1:0] r_color;
    logic               r_plot;

    logic               w_sweep;
    logic [CNT_W-1:0]   w_row;
    logic [CNT_W-1:0]   w_col;
    logic               w_last;
    logic               w_tick;
    logic [X_W-1:0]     w_move_x;
    logic [Y_W-1:0]     w_move_y;
    logic               w_move_dir_x;
    logic               w_move_dir_y;

    assign w_sweep    = (r_state == S_DRAW) || (r_state == S_ERASE);
    assign w_tick     = (r_state == S_WAIT) && go && (r_delay == '0);
    assign busy       = (r_state == S_DRAW) || (r_state == S_ERASE) || (r_state == S_MOVE);
    assign frame_tick = w_tick;

    box_pixel_sweep #(
        .BOX_SIZE (BOX_SIZE),
        .CNT_W    (CNT_W)
    ) u_sweep (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (!w_sweep),
        .i_enable (w_sweep),
        .o_row    (w_row),
        .o_col    (w_col),
        .o_last   (w_last)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (go) w_next = S_DRAW;
            S_DRAW:  if (w_last) w_next = S_WAIT;
`ifdef SPRITE_TRAIL_EN
            S_WAIT:  if (w_tick && (r_frame == '0)) w_next = S_MOVE;
`else
            S_WAIT:  if (w_tick && (r_frame == '0)) w_next = S_ERASE;
`endif
            S_ERASE: if (w_last) w_next = S_MOVE;
            S_MOVE:  w_next = S_DRAW;
            default: w_next = S_IDLE;
        endcase
    end

    // Bounce arithmetic: clamp to the edge and reverse when the next step would reach it.
    always_comb begin
        w_move_x     = r_pos_x;
        w_move_dir_x = r_dir_x;
        if ((r_dir_x == DIR_POS) && (({1'b0, r_pos_x} + STEP_X) >= MAX_X)) begin
            w_move_x     = MAX_X[X_W-1:0];
            w_move_dir_x = DIR_NEG;
        end else if ((r_dir_x == DIR_NEG) && ({1'b0, r_pos_x} <= STEP_X)) begin
            w_move_x     = '0;
            w_move_dir_x = DIR_POS;
        end else if (r_dir_x == DIR_POS) begin
            w_move_x = r_pos_x + STEP_X[X_W-1:0];
        end else begin
            w_move_x = r_pos_x - STEP_X[X_W-1:0];
        end

        w_move_y     = r_pos_y;
        w_move_dir_y = r_dir_y;
        if ((r_dir_y == DIR_POS) && (({1'b0, r_pos_y} + STEP_Y) >= MAX_Y)) begin
            w_move_y     = MAX_Y[Y_W-1:0];
            w_move_dir_y = DIR_NEG;
        end else if ((r_dir_y == DIR_NEG) && ({1'b0, r_pos_y} <= STEP_Y)) begin
            w_move_y     = '0;
            w_move_dir_y = DIR_POS;
        end else if (r_dir_y == DIR_POS) begin
            w_move_y = r_pos_y + STEP_Y[Y_W-1:0];
        end else begin
            w_move_y = r_pos_y - STEP_Y[Y_W-1:0];
        end
    end

    // Sprite position, direction and colour: loaded (clamped) in IDLE, stepped in MOVE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pos_x        <= '0;
            r_pos_y        <= '0;
            r_dir_x        <= DIR_POS;
            r_dir_y        <= DIR_POS;
            r_sprite_color <= '0;
        end else if ((r_state == S_IDLE) && load) begin
            r_pos_x        <= ({1'b0, x_init} > MAX_X) ? MAX_X[X_W-1:0] : x_init;
            r_pos_y        <= ({1'b0, y_init} > MAX_Y) ? MAX_Y[Y_W-1:0] : y_init;
            r_sprite_color <= color_in;
        end else if (r_state == S_MOVE) begin
            r_pos_x <= w_move_x;
            r_pos_y <= w_move_y;
            r_dir_x <= w_move_dir_x;
            r_dir_y <= w_move_dir_y;
        end
    end

    // Frame timing: counters only run in WAIT while go is held, so dropping go pauses them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_delay <= DELAY_RELOAD;
            r_frame <= FRAME_RELOAD;
        end else if ((r_state == S_WAIT) && go) begin
            if (r_delay == '0) begin
                r_delay <= DELAY_RELOAD;
                r_frame <= (r_frame == '0) ? FRAME_RELOAD : r_frame - 1'b1;
            end else begin
                r_delay <= r_delay - 1'b1;
            end
        end
    end

    // Registered pixel port: the pixel addressed by the sweep this cycle is presented next cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
            r_plot  <= 1'b0;
        end else begin
            r_plot <= w_sweep;
            if (w_sweep) begin
                r_x     <= r_pos_x + X_W'(w_col);
                r_y     <= r_pos_y + Y_W'(w_row);
                r_color <= (r_state == S_DRAW) ? r_sprite_color : COLOR_W'(COLOR_BLACK);
            end
        end
    end

    assign x     = r_x;
    assign y     = r_y;
    assign color = r_color;
    assign plot  = r_plot;

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Directed bench for bounce_sprite_engine on a 16x8 screen with a 2x2 sprite,
// 4 cycles per frame and 2 frames per step.
module tb_bounce_sprite_engine;

    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int COLOR_W = 3;

    logic               clock    = 1'b0;
    logic               reset    = 1'b0;
    logic               load     = 1'b0;
    logic               go       = 1'b0;
    logic [X_W-1:0]     x_init   = '0;
    logic [Y_W-1:0]     y_init   = '0;
    logic [COLOR_W-1:0] color_in = '0;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
    logic               plot;
    logic               busy;
    logic               frame_tick;

    int total = 0;
    int bad   = 0;

    bounce_sprite_engine #(
        .X_W             (X_W),
        .Y_W             (Y_W),
        .COLOR_W         (COLOR_W),
        .SCREEN_W        (16),
        .SCREEN_H        (8),
        .BOX_SIZE        (2),
        .STEP            (1),
        .TICKS_PER_FRAME (4),
        .FRAMES_PER_STEP (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .go         (go),
        .x_init     (x_init),
        .y_init     (y_init),
        .color_in   (color_in),
        .x          (x),
        .y          (y),
        .color      (color),
        .plot       (plot),
        .busy       (busy),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Skip the current plot burst, then stop on the first pixel of the next coloured draw.
    task automatic next_draw(input string tag, input int ex, input int ey, input int ec);
        int n;
        n = 0;
        while ((plot !== 1'b0) && (n < 60)) begin
            tick();
            n++;
        end
        while (!((plot === 1'b1) && (color !== '0)) && (n < 60)) begin
            tick();
            n++;
        end
        total++;
        assert (n < 60) else begin
            bad++;
            $error("FAIL %s_timeout: waited=%0d cycles, required < 60", tag, n);
        end
        check({tag, "_x"}, 32'(x), ex);
        check({tag, "_y"}, 32'(y), ey);
        check({tag, "_color"}, 32'(color), ec);
    endtask

    task automatic start(input logic [X_W-1:0] sx, input logic [Y_W-1:0] sy,
                         input logic [COLOR_W-1:0] sc);
        reset = 1'b0;
        go    = 1'b0;
        load  = 1'b0;
        tick();
        reset    = 1'b1;
        load     = 1'b1;
        go       = 1'b1;
        x_init   = sx;
        y_init   = sy;
        color_in = sc;
        tick();
        load = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        tick();
        tick();
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_color", 32'(color), 0);
        check("rst_plot", 32'(plot), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_tick", 32'(frame_tick), 0);

        // Load and go together: first draw at (3,2) colour 5
        reset    = 1'b1;
        load     = 1'b1;
        go       = 1'b1;
        x_init   = 8'd3;
        y_init   = 7'd2;
        color_in = 3'd5;
        tick();
        load = 1'b0;
        check("draw1_entry_busy", 32'(busy), 1);
        check("draw1_entry_plot", 32'(plot), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("draw1_px%0d_plot", k), 32'(plot), 1);
            check($sformatf("draw1_px%0d_x", k), 32'(x), 3 + (k % 2));
            check($sformatf("draw1_px%0d_y", k), 32'(y), 2 + (k / 2));
            check($sformatf("draw1_px%0d_color", k), 32'(color), 5);
        end
        check("wait1_busy", 32'(busy), 0);

        // WAIT with go held: frame_tick on the 4th and 8th cycle, leave on the 8th
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("wait1_c%0d_tick", i), 32'(frame_tick), 32'((i == 3) || (i == 7)));
            check($sformatf("wait1_c%0d_plot", i), 32'(plot), 0);
        end
        check("wait1_exit_busy", 32'(busy), 1);

`ifndef SPRITE_TRAIL_EN
        // Erase the old box in black
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("erase1_px%0d_plot", k), 32'(plot), 1);
            check($sformatf("erase1_px%0d_x", k), 32'(x), 3 + (k % 2));
            check($sformatf("erase1_px%0d_y", k), 32'(y), 2 + (k / 2));
            check($sformatf("erase1_px%0d_color", k), 32'(color), 0);
        end
        tick();
`else
        tick();
`endif
        check("move1_plot", 32'(plot), 0);
        check("move1_busy", 32'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("draw2_px%0d_plot", k), 32'(plot), 1);
            check($sformatf("draw2_px%0d_x", k), 32'(x), 4 + (k % 2));
            check($sformatf("draw2_px%0d_y", k), 32'(y), 3 + (k / 2));
            check($sformatf("draw2_px%0d_color", k), 32'(color), 5);
        end

        // Pause in WAIT exactly when the delay counter has reached zero
        tick();
        tick();
        tick();
        check("pre_pause_tick", 32'(frame_tick), 1);
        go       = 1'b0;
        load     = 1'b1;
        x_init   = 8'd0;
        y_init   = 7'd0;
        color_in = 3'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("pause_c%0d_tick", i), 32'(frame_tick), 0);
            check($sformatf("pause_c%0d_plot", i), 32'(plot), 0);
            check($sformatf("pause_c%0d_busy", i), 32'(busy), 0);
        end
        go   = 1'b1;
        load = 1'b0;
        #1;
        check("resume_tick", 32'(frame_tick), 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("resume_c%0d_tick", i), 32'(frame_tick), 32'(i == 4));
        end
        check("resume_c4_busy", 32'(busy), 0);
        tick();
        check("resume_c5_busy", 32'(busy), 1);
        // Load while not idle is ignored: the box keeps bouncing from (4,3)
        next_draw("step2", 5, 4, 5);

        // Corner start: first step pins to the corner and flips both axes, second moves back
        start(8'd14, 7'd6, 3'd2);
        next_draw("corner0", 14, 6, 2);
        next_draw("corner1", 14, 6, 2);
        next_draw("corner2", 13, 5, 2);

        // Oversized load values are clamped to the last legal position
        start(8'd200, 7'd7, 3'd3);
        next_draw("clamp", 14, 6, 3);

        // Reset after two pixels of a draw aborts the sweep
        start(8'd3, 7'd2, 3'd5);
        tick();
        tick();
        check("mid_px1_plot", 32'(plot), 1);
        check("mid_px1_x", 32'(x), 4);
        reset = 1'b0;
        tick();
        check("mid_rst_plot", 32'(plot), 0);
        check("mid_rst_x", 32'(x), 0);
        check("mid_rst_y", 32'(y), 0);
        check("mid_rst_color", 32'(color), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_frame_tick", 32'(frame_tick), 0);
        reset = 1'b1;
        go    = 1'b0;
        tick();
        tick();
        check("idle_after_rst_busy", 32'(busy), 0);
        check("idle_after_rst_plot", 32'(plot), 0);
        // A fresh draw starts from the first pixel of the box
        load     = 1'b1;
        go       = 1'b1;
        x_init   = 8'd7;
        y_init   = 7'd1;
        color_in = 3'd6;
        tick();
        load = 1'b0;
        next_draw("post_rst", 7, 1, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
